// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding, count width
// and the prescaler width helper.
package countdown_timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int COUNT_W = 8;

   // Prescaler width is ceil(log2(prescale)), but never narrower than one bit.
   function automatic int presc_width(input int prescale);
      return (prescale <= 2) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/equal_zero.sv
// Zero detector: flags when the input word is all zeros.
module equal_zero #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_value,
   output logic             o_zero
);

   assign o_zero = (i_value == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable 8-bit down-counter with prescaler, pause/abort control and a
// registered expiry strobe; optional auto-reload keeps it running periodically.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int PRESCALE    = 1,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load_valid,
   input  logic [COUNT_W-1:0] i_load_value,
   output logic               o_load_ready,
   input  logic               i_pause,
   input  logic               i_abort,
   output logic [COUNT_W-1:0] o_count,
   output logic               o_busy,
   output logic               o_expire,
   output logic               o_zero
);

   localparam int              PS_W   = presc_width(PRESCALE);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);

   state_t             state_r,  state_n;
   logic [COUNT_W-1:0] count_r,  count_n;
   logic [COUNT_W-1:0] reload_r, reload_n;
   logic [PS_W-1:0]    presc_r,  presc_n;
   logic               expire_r, expire_n;
   logic               tick;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r  <= ST_IDLE;
         count_r  <= '0;
         reload_r <= '0;
         presc_r  <= '0;
         expire_r <= 1'b0;
      end else begin
         state_r  <= state_n;
         count_r  <= count_n;
         reload_r <= reload_n;
         presc_r  <= presc_n;
         expire_r <= expire_n;
      end
   end

   always_comb begin
      state_n  = state_r;
      count_n  = count_r;
      reload_n = reload_r;
      presc_n  = presc_r;
      expire_n = 1'b0;
      tick     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // Pause and abort have no meaning here; only the load port matters.
            if (i_load_valid) begin
               count_n  = i_load_value;
               reload_n = i_load_value;
               presc_n  = '0;
               if (i_load_value != '0) state_n  = ST_RUN;
               else                    expire_n = 1'b1;
            end
         end
         ST_RUN: begin
            if (i_abort) begin
               state_n = ST_IDLE;
               count_n = '0;
               presc_n = '0;
            end else if (!i_pause) begin
               if (presc_r == PS_MAX) begin
                  presc_n = '0;
                  tick    = 1'b1;
               end else begin
                  presc_n = presc_r + PS_ONE;
               end
            end
            // RUN is only entered with a non-zero count, so the last tick sees 1.
            if (tick) begin
               if (count_r > COUNT_W'(1)) begin
                  count_n = count_r - COUNT_W'(1);
               end else begin
                  expire_n = 1'b1;
                  if (AUTO_RELOAD) begin
                     count_n = reload_r;
                  end else begin
                     count_n = '0;
                     state_n = ST_IDLE;
                  end
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign o_count      = count_r;
   assign o_busy       = (state_r == ST_RUN);
   assign o_load_ready = (state_r == ST_IDLE);
   assign o_expire     = expire_r;

   equal_zero #(
      .WIDTH (COUNT_W)
   ) u_equal_zero (
      .i_value (count_r),
      .o_zero  (o_zero)
   );

endmodule
